// File: rtl/wb_trace_collector.sv
// Writeback trace collector: shadow register file, trace FIFO and register dump streamer.
// Optional running writeback signature enabled by defining WB_TRACE_SIG_EN.
`timescale 1ns/1ps
module wb_trace_collector #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_e,
  input  logic [4:0]       wb_a,
  input  logic [31:0]      wb_d,
  input  logic [31:0]      pc_in,
  input  logic             dump,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_kind,
  output logic [4:0]       out_addr,
  output logic [31:0]      out_data,
  output logic [31:0]      out_pc,
  output logic             overflow,
  output logic             busy,
  output logic             dump_done,
  output logic [CNT_W-1:0] event_count,
  output logic [31:0]      sig
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DUMP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [68:0]       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic [31:0]       shadow_q [32];
  logic [4:0]        idx_q, idx_d;
  logic              overflow_q;
  logic [CNT_W-1:0]  event_count_q;

  logic        capture, fifo_full, fifo_nonempty, push, pop;
  logic [68:0] head;

  assign capture       = wb_e && (wb_a != 5'd0) && ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign fifo_full     = (count_q == FULL_CNT);
  assign fifo_nonempty = (count_q != {(AW+1){1'b0}});
  // A pop in the same cycle never makes room for a push into a full FIFO.
  assign push          = capture && !fifo_full;
  assign pop           = ((state_q == S_RUN) || (state_q == S_DRAIN)) && fifo_nonempty && out_ready;
  assign head          = mem_q[rd_ptr_q];

  assign overflow    = overflow_q;
  assign event_count = event_count_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    out_valid = 1'b0;
    out_kind  = 1'b0;
    out_addr  = 5'd0;
    out_data  = 32'd0;
    out_pc    = 32'd0;
    busy      = 1'b0;
    dump_done = 1'b0;
    case (state_q)
      S_RUN, S_DRAIN: begin
        if (fifo_nonempty) begin
          out_valid = 1'b1;
          out_addr  = head[68:64];
          out_data  = head[63:32];
          out_pc    = head[31:0];
        end else begin
          out_valid = 1'b0;
        end
        if (state_q == S_RUN) begin
          state_d = dump ? S_DRAIN : S_RUN;
        end else begin
          busy    = 1'b1;
          state_d = (!fifo_nonempty && !push) ? S_DUMP : S_DRAIN;
        end
      end
      S_DUMP: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_kind  = 1'b1;
        out_addr  = idx_q;
        out_data  = (idx_q == 5'd0) ? 32'd0 : shadow_q[idx_q];
        if (out_ready && (idx_q == 5'd31)) begin
          state_d = S_DONE;
          idx_d   = 5'd0;
        end else if (out_ready) begin
          idx_d = idx_q + 5'd1;
        end else begin
          idx_d = idx_q;
        end
      end
      S_DONE: begin
        dump_done = 1'b1;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Trace storage needs no reset: the occupancy count qualifies every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {wb_a, wb_d, pc_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_RUN;
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      count_q       <= {(AW+1){1'b0}};
      idx_q         <= 5'd0;
      overflow_q    <= 1'b0;
      event_count_q <= {CNT_W{1'b0}};
      for (int i = 0; i < 32; i++) begin
        shadow_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        if (event_count_q != {CNT_W{1'b1}}) begin
          event_count_q <= event_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      end
      if (capture) begin
        shadow_q[wb_a] <= wb_d;
        if (fifo_full) begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

`ifdef WB_TRACE_SIG_EN
  logic [31:0] sig_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sig_q <= 32'd0;
    end else if (capture) begin
      sig_q <= {sig_q[30:0], sig_q[31]} ^ wb_d ^ {27'b0, wb_a};
    end
  end

  assign sig = sig_q;
`else
  assign sig = 32'd0;
`endif

endmodule

// File: tb/tb_wb_trace_collector.sv
// Scoreboard bench for wb_trace_collector: expected records queued at stimulus time, checked on transfer.
`timescale 1ns/1ps
module tb_wb_trace_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_e = 1'b0;
  logic [4:0]  wb_a = 5'd0;
  logic [31:0] wb_d = 32'd0;
  logic [31:0] pc_in = 32'd0;
  logic        dump = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_kind, overflow, busy, dump_done;
  logic [4:0]  out_addr;
  logic [31:0] out_data, out_pc, sig;
  logic [15:0] event_count;

  int n_cmp = 0;
  int n_err = 0;
  int n_xfer = 0;
  int n_dump = 0;
  logic [69:0] sb[$];
  logic [31:0] shadow_m [32];

  wb_trace_collector #(.DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .wb_e(wb_e), .wb_a(wb_a), .wb_d(wb_d), .pc_in(pc_in),
    .dump(dump), .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_addr(out_addr), .out_data(out_data), .out_pc(out_pc), .overflow(overflow),
    .busy(busy), .dump_done(dump_done), .event_count(event_count), .sig(sig)
  );

  always #5 clk = ~clk;

  // Transfers are judged on the falling edge before the rising edge that commits them.
  logic [69:0] held_rec;
  logic        held = 1'b0;
  always @(negedge clk) begin
    logic [69:0] cur, want;
    cur = {out_kind, out_addr, out_data, out_pc};
    if (!reset && held && out_valid) begin
      n_cmp++;
      if (cur !== held_rec) begin
        n_err++;
        $display("FAIL stable_fields got=%h want=%h", cur, held_rec);
      end
    end
    held     = !reset && out_valid && !out_ready;
    held_rec = cur;
    if (!reset && out_valid && out_ready) begin
      n_cmp++;
      n_xfer++;
      if (out_kind) n_dump++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_record got=%h want=none", cur);
      end else begin
        want = sb.pop_front();
        if (cur !== want) begin
          n_err++;
          $display("FAIL record got=%h want=%h", cur, want);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    sb.delete();
    for (int i = 0; i < 32; i++) shadow_m[i] = 32'd0;
    n_xfer = 0;
    n_dump = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; wb_e = 1'b0; dump = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    clear_model();
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d, input logic [31:0] p,
                    input bit cap, input bit acc);
    wb_e = 1'b1; wb_a = a; wb_d = d; pc_in = p;
    if (cap && a != 5'd0) shadow_m[a] = d;
    if (acc) sb.push_back({1'b0, a, d, p});
    tick();
    wb_e = 1'b0;
  endtask

  task automatic start_dump();
    for (int i = 0; i < 32; i++) sb.push_back({1'b1, 5'(i), shadow_m[i], 32'd0});
    dump = 1'b1;
    tick();
    dump = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL busy_after_dump got=%b want=1", busy); end
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 300; k++) begin
      if (dump_done === 1'b1) break;
      tick();
    end
    n_cmp++;
    if (dump_done !== 1'b1) begin n_err++; $display("FAIL dump_done_timeout got=%b want=1", dump_done); end
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
  endtask

  task automatic test_reset();
    wb_e = 1'b1; wb_a = 5'd3; wb_d = 32'h5; dump = 1'b1; out_ready = 1'b1;
    tick(); tick();
    apply_reset();
    n_cmp++;
    if ({out_valid, overflow, busy, dump_done} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags got=%b want=0000", {out_valid, overflow, busy, dump_done});
    end
    n_cmp++;
    if (event_count !== 16'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", event_count); end
    n_cmp++;
    if (sig !== 32'd0) begin n_err++; $display("FAIL reset_sig got=%h want=0", sig); end
  endtask

  task automatic test_single();
    apply_reset();
    out_ready = 1'b1;
    wb(5'd1, 32'hDEADBEEF, 32'd0, 1'b1, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b want=1", out_valid); end
    n_cmp++;
    if (event_count !== 16'd1) begin n_err++; $display("FAIL single_count got=%0d want=1", event_count); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_popped got=%b want=0", out_valid); end
  endtask

  task automatic test_x0_ignored();
    wb(5'd0, 32'd5, 32'h40, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL x0_valid got=%b want=0", out_valid); end
    n_cmp++;
    if (event_count !== 16'd1) begin n_err++; $display("FAIL x0_count got=%0d want=1", event_count); end
  endtask

  task automatic test_overflow();
    int k;
    apply_reset();
    for (int i = 1; i <= 17; i++) wb(5'(i), 32'(i), 32'(i * 4), 1'b1, i <= 16);
    n_cmp++;
    if (event_count !== 16'd16) begin n_err++; $display("FAIL ovf_count got=%0d want=16", event_count); end
    n_cmp++;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got=%b want=1", overflow); end
    out_ready = 1'b1;
    for (k = 0; k < 100 && sb.size() != 0; k++) tick();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      n_err++; $display("FAIL ovf_drain got=%b/%0d want=0/0", out_valid, sb.size());
    end
    start_dump();
    wait_done();
  endtask

  task automatic test_dump();
    apply_reset();
    wb(5'd1, 32'hDEADBEEF, 32'h100, 1'b1, 1'b1);
    wb(5'd2, 32'h12345678, 32'h104, 1'b1, 1'b1);
    wb(5'd7, 32'd4, 32'h108, 1'b1, 1'b1);
    wb(5'd3, 32'hFEDCBA98, 32'h10C, 1'b1, 1'b1);
    out_ready = 1'b1;
    start_dump();
    wait_done();
    n_cmp++;
    if (n_xfer != 36) begin n_err++; $display("FAIL dump_xfers got=%0d want=36", n_xfer); end
    wb(5'd9, 32'h99, 32'h200, 1'b0, 1'b0);
    dump = 1'b1;
    wb(5'd10, 32'hAA, 32'h204, 1'b0, 1'b0);
    dump = 1'b0;
    tick();
    n_cmp++;
    if ({out_valid, dump_done, busy} !== 3'b010 || event_count !== 16'd4) begin
      n_err++; $display("FAIL done_hold got=%b cnt=%0d want=010 cnt=4", {out_valid, dump_done, busy}, event_count);
    end
  endtask

  task automatic test_reset_mid_dump();
    int k;
    apply_reset();
    for (int i = 1; i <= 17; i++) wb(5'(i), 32'(i * 17), 32'(i * 4), 1'b1, i <= 16);
    out_ready = 1'b1;
    start_dump();
    for (k = 0; k < 200 && n_dump < 10; k++) tick();
    n_cmp++;
    if (n_dump != 10) begin n_err++; $display("FAIL mid_dump_reach got=%0d want=10", n_dump); end
    reset = 1'b1; out_ready = 1'b0;
    tick();
    n_cmp++;
    if ({out_valid, busy, dump_done, overflow} !== 4'b0000 || event_count !== 16'd0) begin
      n_err++; $display("FAIL mid_reset got=%b cnt=%0d want=0000 cnt=0", {out_valid, busy, dump_done, overflow}, event_count);
    end
    reset = 1'b0;
    clear_model();
    out_ready = 1'b1;
    start_dump();
    wait_done();
  endtask

  task automatic test_sig();
    logic [31:0] e1, e2;
`ifdef WB_TRACE_SIG_EN
    e1 = 32'h00000012; e2 = 32'h00000024;
`else
    e1 = 32'd0; e2 = 32'd0;
`endif
    apply_reset();
    out_ready = 1'b1;
    wb(5'd2, 32'h10, 32'h0, 1'b1, 1'b1);
    n_cmp++;
    if (sig !== e1) begin n_err++; $display("FAIL sig_first got=%h want=%h", sig, e1); end
    wb(5'd1, 32'h1, 32'h4, 1'b1, 1'b1);
    n_cmp++;
    if (sig !== e2) begin n_err++; $display("FAIL sig_second got=%h want=%h", sig, e2); end
    tick(); tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    test_reset();
    test_single();
    test_x0_ignored();
    test_overflow();
    test_dump();
    test_reset_mid_dump();
    test_sig();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
